// File: rtl/keypad_encoder.sv
// One-hot keypad bus to binary key code with a one-cycle valid strobe, multi-key rejection,
// release detection and attempt lockout. Define DEBOUNCE_EN to add the stable-input debounce.
module keypad_encoder #(
   parameter int unsigned N_KEYS    = 16,
   parameter int unsigned CODE_W    = 4,
   parameter int unsigned MAX_TRIES = 5,
   parameter int unsigned TRIES_W   = 8,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_KEYS-1:0]  onehot,
   input  logic               clr,
   output logic [CODE_W-1:0]  code,
   output logic               code_valid,
   output logic               err_multi,
   output logic [TRIES_W-1:0] tries,
   output logic               locked
);

`ifdef DEBOUNCE_EN
   typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StLocked} state_e;
   localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_KEYS-1:0] pat_q, pat_d;
`else
   typedef enum logic [1:0] {StIdle, StHeld, StLocked} state_e;
`endif

   state_e             state_q, state_d;
   logic [N_KEYS-1:0]  onehot_q;
   logic [CODE_W-1:0]  code_q, code_d;
   logic               code_valid_q, code_valid_d;
   logic               err_multi_q, err_multi_d;
   logic [TRIES_W-1:0] tries_q, tries_d;
   logic               locked_q, locked_d;
   logic [CODE_W-1:0]  key_idx;
   logic               any_key, multi_key, accept;

   assign any_key   = |onehot_q;
   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign multi_key = |(onehot_q & (onehot_q - N_KEYS'(1)));

   always_comb begin
      key_idx = '0;
      for (int i = 0; i < int'(N_KEYS); i++) begin
         if (onehot_q[i]) key_idx = CODE_W'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      err_multi_d  = 1'b0;
      tries_d      = tries_q;
      locked_d     = locked_q;
      accept       = 1'b0;
`ifdef DEBOUNCE_EN
      cnt_d        = cnt_q;
      pat_d        = pat_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (multi_key) begin
               err_multi_d = 1'b1;
               state_d     = StHeld;
            end else if (any_key) begin
`ifdef DEBOUNCE_EN
               pat_d   = onehot_q;
               cnt_d   = '0;
               state_d = StDebounce;
`else
               accept  = 1'b1;
`endif
            end
         end
`ifdef DEBOUNCE_EN
         StDebounce: begin
            if (onehot_q != pat_q) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(DB_CYCLES)) accept = 1'b1;
            end
         end
`endif
         StHeld: begin
            if (!any_key) state_d = StIdle;
         end
         StLocked: ;
         default: state_d = StIdle;
      endcase

      if (accept) begin
         code_d       = key_idx;
         code_valid_d = 1'b1;
         tries_d      = tries_q + TRIES_W'(1);
         if (tries_d == TRIES_W'(MAX_TRIES)) begin
            locked_d = 1'b1;
            state_d  = StLocked;
         end else begin
            state_d  = StHeld;
         end
      end

      // clr overrides everything, including an accept on the same edge; code is kept.
      if (clr) begin
         code_d       = code_q;
         code_valid_d = 1'b0;
         err_multi_d  = 1'b0;
         tries_d      = '0;
         locked_d     = 1'b0;
         state_d      = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         onehot_q     <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         err_multi_q  <= 1'b0;
         tries_q      <= '0;
         locked_q     <= 1'b0;
`ifdef DEBOUNCE_EN
         cnt_q        <= '0;
         pat_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         onehot_q     <= onehot;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         err_multi_q  <= err_multi_d;
         tries_q      <= tries_d;
         locked_q     <= locked_d;
`ifdef DEBOUNCE_EN
         cnt_q        <= cnt_d;
         pat_q        <= pat_d;
`endif
      end
   end

   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign err_multi  = err_multi_q;
   assign tries      = tries_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed scenarios with literal expectations plus
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_keypad_encoder;
   localparam int unsigned NKeys    = 16;
   localparam int unsigned CodeW    = 4;
   localparam int unsigned MaxTries = 5;
   localparam int unsigned TriesW   = 8;
   localparam int unsigned DbCycles = 4;
`ifdef DEBOUNCE_EN
   localparam int unsigned Dly = DbCycles;
`else
   localparam int unsigned Dly = 0;
`endif
   localparam int BouncePulses = (Dly == 0) ? 4 : 0;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic              clr   = 1'b0;
   logic [NKeys-1:0]  onehot = '0;
   logic [CodeW-1:0]  code;
   logic              code_valid;
   logic              err_multi;
   logic [TriesW-1:0] tries;
   logic              locked;

   int checks  = 0;
   int errors  = 0;
   int vpulses = 0;
   int epulses = 0;

   // Model state: sampled input, press streak, armed (waiting for a new press), outputs.
   logic [NKeys-1:0] m_s      = '0;
   logic [NKeys-1:0] m_pat    = '0;
   int               m_streak = 0;
   bit               m_armed  = 1'b1;
   int               m_tries  = 0;
   bit               m_locked = 1'b0;
   int               m_code   = 0;
   bit               m_valid  = 1'b0;
   bit               m_err    = 1'b0;

   keypad_encoder #(
      .N_KEYS   (NKeys),
      .CODE_W   (CodeW),
      .MAX_TRIES(MaxTries),
      .TRIES_W  (TriesW),
      .DB_CYCLES(DbCycles)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .onehot    (onehot),
      .clr       (clr),
      .code      (code),
      .code_valid(code_valid),
      .err_multi (err_multi),
      .tries     (tries),
      .locked    (locked)
   );

   initial forever #5 clk = ~clk;

   function automatic int idx(input logic [NKeys-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < int'(NKeys); i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
   endtask

   // Behavioural model: a press is accepted once the same single key has been seen on
   // Dly+1 consecutive sampled edges while armed; a change mid-streak discards that edge.
   initial begin : model
      logic [NKeys-1:0] s;
      bit acc;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_s = '0; m_pat = '0; m_streak = 0; m_armed = 1'b1;
            m_tries = 0; m_locked = 1'b0; m_code = 0; m_valid = 1'b0; m_err = 1'b0;
         end else begin
            s       = m_s;
            m_s     = onehot;
            m_valid = 1'b0;
            m_err   = 1'b0;
            acc     = 1'b0;
            if (clr) begin
               m_tries = 0; m_locked = 1'b0; m_armed = 1'b1; m_streak = 0;
            end else if (!m_locked) begin
               if (m_streak > 0) begin
                  if (s != m_pat) m_streak = 0;
                  else begin
                     m_streak++;
                     if (m_streak == int'(Dly) + 1) acc = 1'b1;
                  end
               end else if (!m_armed) begin
                  if (s == '0) m_armed = 1'b1;
               end else if (s != '0) begin
                  if ($countones(s) > 1) begin
                     m_err   = 1'b1;
                     m_armed = 1'b0;
                  end else begin
                     m_pat = s;
                     if (Dly == 0) acc = 1'b1;
                     else m_streak = 1;
                  end
               end
               if (acc) begin
                  m_valid  = 1'b1;
                  m_code   = idx(m_pat);
                  m_tries++;
                  m_streak = 0;
                  m_armed  = 1'b0;
                  if (m_tries == int'(MaxTries)) m_locked = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("code", 32'(code), 32'(m_code));
      check("code_valid", 32'(code_valid), 32'(m_valid));
      check("err_multi", 32'(err_multi), 32'(m_err));
      check("tries", 32'(tries), 32'(m_tries));
      check("locked", 32'(locked), 32'(m_locked));
      if (code_valid === 1'b1) vpulses++;
      if (err_multi === 1'b1) epulses++;
   end

   initial begin : stim
      int lat;
      int r;
      #1 rst_n = 1'b0;
      cyc(3);
      check("reset_code", 32'(code), 0);
      check("reset_valid", 32'(code_valid), 0);
      check("reset_tries", 32'(tries), 0);
      check("reset_locked", 32'(locked), 0);
      rst_n = 1'b1;
      cyc(2);

      // Single press, release, re-press.
      vpulses = 0;
      onehot = 16'h0020; cyc(8);
      check("press1_pulses", 32'(vpulses), 1);
      check("press1_code", 32'(code), 5);
      check("press1_tries", 32'(tries), 1);
      onehot = '0; cyc(3);
      vpulses = 0;
      onehot = 16'h0020; cyc(8);
      check("press2_pulses", 32'(vpulses), 1);
      check("press2_tries", 32'(tries), 2);

      // Bounce then steady hold.
      onehot = '0; cyc(2); pulse_clr(); cyc(1);
      vpulses = 0;
      repeat (4) begin
         onehot = 16'h0080; cyc(2);
         onehot = '0;       cyc(2);
      end
      check("bounce_pulses", 32'(vpulses), 32'(BouncePulses));
      vpulses = 0;
      onehot = 16'h0080; cyc(8);
      check("hold_pulses", 32'(vpulses), 1);
      check("hold_code", 32'(code), 7);

      // Multi-key rejection.
      onehot = '0; cyc(2); pulse_clr(); cyc(1);
      vpulses = 0; epulses = 0;
      onehot = 16'h0420; cyc(8);
      check("multi_err_pulses", 32'(epulses), 1);
      check("multi_valid_pulses", 32'(vpulses), 0);
      check("multi_code_kept", 32'(code), 7);
      onehot = '0; cyc(3);
      onehot = 16'h0001; cyc(8);
      check("after_multi_code", 32'(code), 0);
      check("after_multi_pulses", 32'(vpulses), 1);

      // Lockout after MaxTries accepts, then clr.
      onehot = '0; cyc(2); pulse_clr(); cyc(1);
      vpulses = 0;
      for (int k = 1; k <= int'(MaxTries); k++) begin
         onehot = 16'(1) << k; cyc(8);
         onehot = '0;          cyc(3);
      end
      check("lock_pulses", 32'(vpulses), 32'(MaxTries));
      check("lock_tries", 32'(tries), 32'(MaxTries));
      check("lock_locked", 32'(locked), 1);
      vpulses = 0;
      onehot = 16'h0200; cyc(8);
      onehot = '0;       cyc(3);
      check("locked_no_pulse", 32'(vpulses), 0);
      check("locked_tries_held", 32'(tries), 32'(MaxTries));
      pulse_clr();
      check("clr_tries", 32'(tries), 0);
      check("clr_locked", 32'(locked), 0);
      onehot = 16'h0008; cyc(8);
      onehot = '0;       cyc(3);
      check("post_clr_pulses", 32'(vpulses), 1);
      check("post_clr_code", 32'(code), 3);
      check("post_clr_tries", 32'(tries), 1);

      // clr on the accept edge.
      vpulses = 0;
      onehot = 16'h0040; cyc(1 + int'(Dly));
      clr = 1'b1; cyc(1);
      check("collide_valid", 32'(code_valid), 0);
      check("collide_tries", 32'(tries), 0);
      check("collide_pulses", 32'(vpulses), 0);
      clr = 1'b0; onehot = '0; cyc(4);

      // Reset mid-operation with the key still held afterwards.
      onehot = 16'h0100; cyc(2);
      rst_n = 1'b0; #1;
      check("midrst_code", 32'(code), 0);
      check("midrst_valid", 32'(code_valid), 0);
      check("midrst_tries", 32'(tries), 0);
      cyc(2);
      rst_n = 1'b1;
      lat = 0;
      while (lat < 30) begin
         @(negedge clk);
         lat++;
         if (code_valid === 1'b1) break;
      end
      check("midrst_latency", 32'(lat), 32'(3 + Dly));
      #1 check("midrst_code_after", 32'(code), 8);
      @(posedge clk); #1;
      onehot = '0; cyc(3);

      // Randomized stimulus, checked by the model every cycle.
      for (int i = 0; i < 800; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60) begin
         end else if (r < 78) onehot = '0;
         else if (r < 95) onehot = 16'(1) << $urandom_range(0, 15);
         else onehot = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
         clr = ($urandom_range(0, 29) == 0);
         cyc(1);
      end
      clr = 1'b0; onehot = '0;
      cyc(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
